// File: rtl/fft4_frame_loader.sv
// Collects a stream of 4-bit samples into 4-sample frames and hands each
// complete frame to the FFT stage in parallel on x_0..x_3.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_valid  : sample stream, in_sof marks sample x_0 of a frame
//   in_ready          : loader can accept a sample this cycle
//   x_0..x_3/out_valid: registered parallel frame, taken when out_ready=1
//   frame_cnt         : frames handed off (wraps at 256)
//   frame_drop        : one-cycle pulse when a partial frame is discarded
module fft4_frame_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [3:0] x_0,
  output logic [3:0] x_1,
  output logic [3:0] x_2,
  output logic [3:0] x_3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] frame_cnt,
  output logic       frame_drop
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_fill_cnt;
  logic [3:0] r_sh [4];

  logic w_accept;
  logic w_free;
  logic w_hs;

  assign in_ready = (r_state == FILL);
  assign w_accept = in_valid && (r_state == FILL);
  assign w_hs     = out_valid && out_ready;
  assign w_free   = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_fill_cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_sh[i] <= '0;
      end
      x_0        <= '0;
      x_1        <= '0;
      x_2        <= '0;
      x_3        <= '0;
      out_valid  <= 1'b0;
      frame_cnt  <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      if (w_hs) begin
        frame_cnt <= frame_cnt + 8'd1;
        out_valid <= 1'b0;
      end
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (in_sof) begin
              // A new start-of-frame always restarts at slot 0.
              r_sh[0]    <= in_data;
              r_fill_cnt <= 2'd1;
              frame_drop <= (r_fill_cnt != 2'd0);
            end else if (r_fill_cnt == 2'd3) begin
              if (w_free) begin
                // Last sample bypasses the shadow so latency is one cycle.
                x_0       <= r_sh[0];
                x_1       <= r_sh[1];
                x_2       <= r_sh[2];
                x_3       <= in_data;
                out_valid <= 1'b1;
              end else begin
                r_sh[3] <= in_data;
                r_state <= FULL;
              end
              r_fill_cnt <= '0;
            end else begin
              r_sh[r_fill_cnt] <= in_data;
              r_fill_cnt       <= r_fill_cnt + 2'd1;
            end
          end
        end
        FULL: begin
          if (w_hs) begin
            x_0        <= r_sh[0];
            x_1        <= r_sh[1];
            x_2        <= r_sh[2];
            x_3        <= r_sh[3];
            out_valid  <= 1'b1;
            r_state    <= FILL;
            r_fill_cnt <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_frame_loader.sv
module tb_fft4_frame_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [3:0] x_0, x_1, x_2, x_3;
  logic       out_valid;
  logic [7:0] frame_cnt;
  logic       frame_drop;

  int checks = 0;
  int errors = 0;

  fft4_frame_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .x_0        (x_0),
    .x_1        (x_1),
    .x_2        (x_2),
    .x_3        (x_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_cnt  (frame_cnt),
    .frame_drop (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level model: samples gather in a list; a completed frame goes to
  // the output if it is free, otherwise it waits as the single pending frame.
  logic [3:0]  m_part[$];
  logic [15:0] m_pend[$];
  logic [3:0]  m_x[4] = '{default: '0};
  bit          m_valid = 0;
  logic [7:0]  m_cnt = '0;
  bit          m_drop = 0;
  bit          m_live = 0;

  task automatic model_step();
    bit hs, rdy, acc, loaded;
    logic [15:0] f;
    if (rst) begin
      m_part.delete();
      m_pend.delete();
      m_x = '{default: '0};
      m_valid = 0;
      m_cnt = '0;
      m_drop = 0;
      m_live = 1;
    end else if (m_live) begin
      hs = m_valid && out_ready;
      rdy = (m_pend.size() == 0);
      acc = in_valid && rdy;
      loaded = 0;
      m_drop = 0;
      if (hs) m_cnt = m_cnt + 8'd1;
      if (!rdy && hs) begin
        f = m_pend.pop_front();
        m_x = '{f[15:12], f[11:8], f[7:4], f[3:0]};
        loaded = 1;
      end else if (acc) begin
        if (in_sof) begin
          m_drop = (m_part.size() != 0);
          m_part.delete();
          m_part.push_back(in_data);
        end else begin
          m_part.push_back(in_data);
          if (m_part.size() == 4) begin
            f = {m_part[0], m_part[1], m_part[2], m_part[3]};
            if (!m_valid || out_ready) begin
              m_x = '{f[15:12], f[11:8], f[7:4], f[3:0]};
              loaded = 1;
            end else begin
              m_pend.push_back(f);
            end
            m_part.delete();
          end
        end
      end
      if (loaded) m_valid = 1;
      else if (hs) m_valid = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        chk("in_ready", {7'd0, in_ready}, {7'd0, m_pend.size() == 0});
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("frame_drop", {7'd0, frame_drop}, {7'd0, m_drop});
        chk("x_0", {4'd0, x_0}, {4'd0, m_x[0]});
        chk("x_1", {4'd0, x_1}, {4'd0, m_x[1]});
        chk("x_2", {4'd0, x_2}, {4'd0, m_x[2]});
        chk("x_3", {4'd0, x_3}, {4'd0, m_x[3]});
      end
      model_step();
    end
  end

  task automatic cyc(input logic r, input logic v, input logic s,
                     input logic [3:0] d, input logic o);
    rst = r; in_valid = v; in_sof = s; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_frame_cnt", frame_cnt, 8'd0);
    chk("rst_x0", {4'd0, x_0}, 8'd0);

    // Basic frame 1,2,3,4
    cyc(0, 1, 1, 1, 1);
    cyc(0, 1, 0, 2, 1);
    cyc(0, 1, 0, 3, 1);
    cyc(0, 1, 0, 4, 1);
    chk("basic_valid", {7'd0, out_valid}, 8'd1);
    chk("basic_x0", {4'd0, x_0}, 8'd1);
    chk("basic_x1", {4'd0, x_1}, 8'd2);
    chk("basic_x2", {4'd0, x_2}, 8'd3);
    chk("basic_x3", {4'd0, x_3}, 8'd4);
    chk("basic_cnt_pre", frame_cnt, 8'd0);
    cyc(0, 0, 0, 0, 1);
    chk("basic_cnt", frame_cnt, 8'd1);
    chk("basic_valid_clr", {7'd0, out_valid}, 8'd0);

    // Back-pressure: A then B with out_ready low
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 5, 0);
    cyc(0, 1, 0, 6, 0);
    cyc(0, 1, 0, 7, 0);
    cyc(0, 1, 0, 8, 0);
    cyc(0, 1, 1, 9, 0);
    cyc(0, 1, 0, 10, 0);
    cyc(0, 1, 0, 11, 0);
    cyc(0, 1, 0, 12, 0);
    chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
    chk("bp_hold_x0", {4'd0, x_0}, 8'd5);
    chk("bp_hold_x3", {4'd0, x_3}, 8'd8);
    cyc(0, 1, 0, 13, 0);
    chk("bp_still_full", {7'd0, in_ready}, 8'd0);
    chk("bp_still_x1", {4'd0, x_1}, 8'd6);
    cyc(0, 0, 0, 0, 1);
    chk("bp_b_x0", {4'd0, x_0}, 8'd9);
    chk("bp_b_x3", {4'd0, x_3}, 8'd12);
    chk("bp_ready_back", {7'd0, in_ready}, 8'd1);
    chk("bp_cnt", frame_cnt, 8'd1);
    chk("bp_valid_kept", {7'd0, out_valid}, 8'd1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_cnt2", frame_cnt, 8'd2);

    // Resync: 3,4 then 7 with sof, 8,9,10
    cyc(0, 1, 1, 3, 1);
    cyc(0, 1, 0, 4, 1);
    cyc(0, 1, 1, 7, 1);
    chk("resync_drop", {7'd0, frame_drop}, 8'd1);
    cyc(0, 1, 0, 8, 1);
    chk("resync_drop_once", {7'd0, frame_drop}, 8'd0);
    cyc(0, 1, 0, 9, 1);
    cyc(0, 1, 0, 10, 1);
    chk("resync_x0", {4'd0, x_0}, 8'd7);
    chk("resync_x3", {4'd0, x_3}, 8'd10);
    cyc(0, 0, 0, 0, 1);

    // Reset mid-frame, then reset while full
    cyc(0, 1, 1, 2, 1);
    cyc(0, 1, 0, 3, 1);
    cyc(1, 0, 0, 0, 0);
    chk("rmid_valid", {7'd0, out_valid}, 8'd0);
    chk("rmid_ready", {7'd0, in_ready}, 8'd1);
    chk("rmid_drop", {7'd0, frame_drop}, 8'd0);
    chk("rmid_x0", {4'd0, x_0}, 8'd0);
    for (int i = 0; i < 8; i++) cyc(0, 1, (i % 4) == 0, 4'(i + 1), 0);
    chk("rfull_ready", {7'd0, in_ready}, 8'd0);
    cyc(1, 0, 0, 0, 0);
    chk("rfull_ready_after", {7'd0, in_ready}, 8'd1);
    chk("rfull_valid", {7'd0, out_valid}, 8'd0);
    chk("rfull_x3", {4'd0, x_3}, 8'd0);
    chk("rfull_cnt", frame_cnt, 8'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i == 0, 15, 0);
    chk("r15_x0", {4'd0, x_0}, 8'd15);
    chk("r15_x3", {4'd0, x_3}, 8'd15);
    chk("r15_drop", {7'd0, frame_drop}, 8'd0);
    cyc(0, 0, 0, 0, 1);

    // Wrap: 256 back-to-back frames
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) cyc(0, 1, (i % 4) == 0, 4'(1 + i % 15), 1);
    chk("wrap_cnt_255", frame_cnt, 8'd255);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_cnt_0", frame_cnt, 8'd0);

    // Random valid / ready
    for (int i = 0; i < 400; i++)
      cyc(0, 1'($urandom % 2), 0, 4'($urandom_range(1, 15)), 1'($urandom % 2));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
